health_tracker: RTL and testbench
=================================

Name: health_tracker

Overview:
Per-player health bookkeeping for the two-player bomb game. Consumes hit pulses from the explosion/collision logic and applies a post-hit invulnerability window measured in game ticks. Detects end of game and the winner. Drives the 2-bit healthA/healthB values consumed by the seven-segment display driver, plus game-over and winner status for the game controller.

Parameters:
MAX_HEALTH, 3, starting health per player; must be 1..3 to fit the 2-bit health outputs.
INVULN_TICKS, 8, number of tick pulses a player ignores hits after taking one; 0 disables invulnerability.
CNT_W, 4, width of each invulnerability counter; must hold INVULN_TICKS.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
tick  input  1  one-cycle game-tick enable; paces invulnerability countdown
hitA  input  1  player A is inside an active explosion this cycle (level)
hitB  input  1  player B is inside an active explosion this cycle (level)
restart  input  1  start a new round (level, sampled every cycle)
healthA  output  2  player A health, registered
healthB  output  2  player B health, registered
invulnA  output  1  high while player A's invulnerability counter is nonzero
invulnB  output  1  high while player B's invulnerability counter is nonzero
game_over  output  1  high in OVER state
winner  output  2  00 none, 01 A wins, 10 B wins, 11 draw

Behaviour:
- Reset (async, rst=1):
  - healthA = healthB = MAX_HEALTH.
  - Both invulnerability counters = 0; invulnA = invulnB = 0.
  - State PLAY; game_over = 0; winner = 00.
  - All outputs hold these values while rst is high. Reset mid-round abandons the round without completing any pending update.
- States: PLAY, OVER. game_over is a registered decode of the state (1 iff OVER).
- restart = 1, any state, not in reset:
  - Next edge reloads exactly the reset values and enters PLAY.
  - Overrides hits and ticks in the same cycle.
- Hit acceptance (PLAY only). Player X takes a hit on an edge when all hold:
  - hitX = 1;
  - invuln counter X == 0;
  - healthX > 0;
  - restart = 0.
- Effect of an accepted hit, on that edge:
  - healthX <= healthX - 1 (1-cycle latency from hitX to the output).
  - Invuln counter X <= INVULN_TICKS.
- Invulnerability countdown:
  - If no hit is accepted, tick = 1 and the counter is nonzero, the counter decrements by 1.
  - The counter never underflows.
  - Loading on a hit has priority over decrementing, even when tick = 1 on the same cycle.
- Level hit behaviour:
  - A hitX held high produces exactly one decrement per invulnerability window.
  - With INVULN_TICKS = 0, a held hitX decrements every cycle until health reaches 0.
- Simultaneous hits: A and B are evaluated independently on the same edge; both may decrement.
- End detection: evaluated on next-state health, on the same edge as the decrement.
  - Next healthB == 0 and next healthA > 0: enter OVER, winner = 01.
  - Next healthA == 0 and next healthB > 0: enter OVER, winner = 10.
  - Both next values == 0: enter OVER, winner = 11.
  - game_over and a 0 on the health output therefore appear in the same cycle.
- OVER state:
  - Health, winner and game_over are frozen; hits and ticks are ignored.
  - Invuln counters clear to 0 on entry.
  - Leaves OVER only via restart or rst.
- Health never goes below 0 and never exceeds MAX_HEALTH.

Test Plan:
- Reset, then idle 20 cycles with no hits, tick every 4 cycles -> healthA = healthB = 3, invulnA/B = 0, game_over = 0, winner = 00 throughout.
- hitA high for 1 cycle -> healthA = 2 on the next cycle, invulnA = 1. Another hitA pulse 3 ticks later is ignored (healthA stays 2). A hitA after the 8th tick is accepted -> healthA = 1.
- hitB held high continuously with tick every cycle, INVULN_TICKS = 8 -> healthB steps 3→2→1→0 at 9-cycle spacing. game_over = 1 and winner = 01 in the same cycle healthB shows 0.
- Both players at health 1 with counters 0, hitA = hitB = 1 on the same cycle -> next cycle healthA = healthB = 0, winner = 11, game_over = 1. Further hits leave all outputs unchanged.
- In OVER, pulse restart for 1 cycle with hitA = 1 in the same cycle -> next cycle healthA = healthB = 3, game_over = 0, winner = 00, invulnA = 0.
- Assert rst asynchronously mid-round (healthA = 1, invulnA = 1, between clock edges) -> outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/health_tracker.sv
// Per-player health bookkeeping for the two-player bomb game.
// Tracks each player's health and post-hit invulnerability window,
// detects the end of a round and reports the winner.
module health_tracker #(
  parameter int MAX_HEALTH   = 3,
  parameter int INVULN_TICKS = 8,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       hitA,
  input  logic       hitB,
  input  logic       restart,
  output logic [1:0] healthA,
  output logic [1:0] healthB,
  output logic       invulnA,
  output logic       invulnB,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  localparam logic [1:0]       HEALTH_FULL = 2'(MAX_HEALTH);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(INVULN_TICKS);

  state_t           r_state;
  logic [1:0]       r_healthA;
  logic [1:0]       r_healthB;
  logic [CNT_W-1:0] r_cntA;
  logic [CNT_W-1:0] r_cntB;
  logic [1:0]       r_winner;
  logic             r_gameOver;

  state_t           w_nextState;
  logic [1:0]       w_nextHealthA;
  logic [1:0]       w_nextHealthB;
  logic [CNT_W-1:0] w_nextCntA;
  logic [CNT_W-1:0] w_nextCntB;
  logic [1:0]       w_nextWinner;
  logic             w_acceptA;
  logic             w_acceptB;

  // A hit only lands while playing, outside the player's invulnerability
  // window, on a living player, and never on a restart cycle.
  assign w_acceptA = (r_state == PLAY) && hitA && (r_cntA == '0) &&
                     (r_healthA != 2'd0) && !restart;
  assign w_acceptB = (r_state == PLAY) && hitB && (r_cntB == '0) &&
                     (r_healthB != 2'd0) && !restart;

  // Next-state logic: restart wins, then hits/countdown in PLAY, with the
  // end of round decided on the post-hit health values of this same edge.
  always_comb begin
    w_nextState   = r_state;
    w_nextHealthA = r_healthA;
    w_nextHealthB = r_healthB;
    w_nextCntA    = r_cntA;
    w_nextCntB    = r_cntB;
    w_nextWinner  = r_winner;
    if (restart) begin
      w_nextState   = PLAY;
      w_nextHealthA = HEALTH_FULL;
      w_nextHealthB = HEALTH_FULL;
      w_nextCntA    = '0;
      w_nextCntB    = '0;
      w_nextWinner  = 2'b00;
    end else if (r_state == PLAY) begin
      if (w_acceptA) begin
        w_nextHealthA = r_healthA - 2'd1;
        w_nextCntA    = CNT_LOAD;
      end else if (tick && (r_cntA != '0)) begin
        w_nextCntA = r_cntA - 1'b1;
      end
      if (w_acceptB) begin
        w_nextHealthB = r_healthB - 2'd1;
        w_nextCntB    = CNT_LOAD;
      end else if (tick && (r_cntB != '0)) begin
        w_nextCntB = r_cntB - 1'b1;
      end
      if ((w_nextHealthA == 2'd0) || (w_nextHealthB == 2'd0)) begin
        w_nextState  = OVER;
        w_nextCntA   = '0;
        w_nextCntB   = '0;
        w_nextWinner = {(w_nextHealthA == 2'd0), (w_nextHealthB == 2'd0)};
      end
    end
  end

  // State register; OVER simply holds everything until restart or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PLAY;
      r_healthA  <= HEALTH_FULL;
      r_healthB  <= HEALTH_FULL;
      r_cntA     <= '0;
      r_cntB     <= '0;
      r_winner   <= 2'b00;
      r_gameOver <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_healthA  <= w_nextHealthA;
      r_healthB  <= w_nextHealthB;
      r_cntA     <= w_nextCntA;
      r_cntB     <= w_nextCntB;
      r_winner   <= w_nextWinner;
      r_gameOver <= (w_nextState == OVER);
    end
  end

  assign healthA   = r_healthA;
  assign healthB   = r_healthB;
  assign invulnA   = (r_cntA != '0);
  assign invulnB   = (r_cntB != '0);
  assign game_over = r_gameOver;
  assign winner    = r_winner;

endmodule

// File: tb/tb_health_tracker.sv
// Self-checking bench for health_tracker: directed scenarios plus a long
// randomized run, all compared against a round-level behavioural model.
module tb_health_tracker;

  localparam int MAX_HEALTH   = 3;
  localparam int INVULN_TICKS = 8;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       hitA;
  logic       hitB;
  logic       restart;
  logic [1:0] healthA;
  logic [1:0] healthB;
  logic       invulnA;
  logic       invulnB;
  logic       gameOver;
  logic [1:0] winner;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: plain integers describing the round.
  int  mHealthA;
  int  mHealthB;
  int  mWindowA;
  int  mWindowB;
  bit  mOver;
  int  mWinner;

  health_tracker #(
    .MAX_HEALTH  (MAX_HEALTH),
    .INVULN_TICKS(INVULN_TICKS),
    .CNT_W       (4)
  ) dut (
    .clk      (clock),
    .rst      (reset),
    .tick     (tick),
    .hitA     (hitA),
    .hitB     (hitB),
    .restart  (restart),
    .healthA  (healthA),
    .healthB  (healthB),
    .invulnA  (invulnA),
    .invulnB  (invulnB),
    .game_over(gameOver),
    .winner   (winner)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mHealthA = MAX_HEALTH;
    mHealthB = MAX_HEALTH;
    mWindowA = 0;
    mWindowB = 0;
    mOver    = 1'b0;
    mWinner  = 0;
  endtask

  // One clock edge of game rules applied to the model.
  task automatic modelStep(input bit a, input bit b, input bit t, input bit r);
    if (r) begin
      modelReset();
    end else if (!mOver) begin
      if (a && mWindowA == 0 && mHealthA > 0) begin
        mHealthA--;
        mWindowA = INVULN_TICKS;
      end else if (t && mWindowA > 0) begin
        mWindowA--;
      end
      if (b && mWindowB == 0 && mHealthB > 0) begin
        mHealthB--;
        mWindowB = INVULN_TICKS;
      end else if (t && mWindowB > 0) begin
        mWindowB--;
      end
      if (mHealthA == 0 || mHealthB == 0) begin
        mOver    = 1'b1;
        mWindowA = 0;
        mWindowB = 0;
        if (mHealthA == 0 && mHealthB == 0) mWinner = 3;
        else if (mHealthB == 0)             mWinner = 1;
        else                                mWinner = 2;
      end
    end
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, ".healthA"}, int'(healthA), mHealthA);
    checkOutput({phase, ".healthB"}, int'(healthB), mHealthB);
    checkOutput({phase, ".invulnA"}, int'(invulnA), int'(mWindowA != 0));
    checkOutput({phase, ".invulnB"}, int'(invulnB), int'(mWindowB != 0));
    checkOutput({phase, ".gameOver"}, int'(gameOver), int'(mOver));
    checkOutput({phase, ".winner"}, int'(winner), mWinner);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare 1ns later.
  task automatic applyStimulus(input string phase, input bit a, input bit b,
                               input bit t, input bit r);
    hitA    = a;
    hitB    = b;
    tick    = t;
    restart = r;
    @(posedge clock);
    modelStep(a, b, t, r);
    #1;
    checkAll(phase);
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    hitA    = 1'b0;
    hitB    = 1'b0;
    restart = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    reset = 1'b0;

    // Idle: nothing should move.
    for (int i = 0; i < 20; i++) applyStimulus("idle", 1'b0, 1'b0, (i % 4) == 3, 1'b0);

    // Hit window: first hit lands, second inside the window is ignored,
    // third after the 8th tick lands.
    applyStimulus("hit1", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("hit1Health", int'(healthA), 2);
    checkOutput("hit1Invuln", int'(invulnA), 1);
    for (int i = 0; i < 12; i++) applyStimulus("win1", 1'b0, 1'b0, (i % 4) == 3, 1'b0);
    applyStimulus("hit2", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("hit2Ignored", int'(healthA), 2);
    for (int i = 0; i < 20; i++) applyStimulus("win2", 1'b0, 1'b0, (i % 4) == 3, 1'b0);
    applyStimulus("hit3", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("hit3Health", int'(healthA), 1);

    // Held hitB with a tick every cycle: decrements on cycles 1, 10, 19.
    applyStimulus("restart1", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 19; i++) applyStimulus("heldB", 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("heldBHealth", int'(healthB), 0);
    checkOutput("heldBOver", int'(gameOver), 1);
    checkOutput("heldBWinner", int'(winner), 1);
    for (int i = 0; i < 5; i++) applyStimulus("overHold", 1'b1, 1'b1, 1'b1, 1'b0);

    // Restart from OVER overrides a same-cycle hit.
    applyStimulus("restartHit", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("restartHealthA", int'(healthA), 3);
    checkOutput("restartOver", int'(gameOver), 0);

    // Both held: simultaneous final hits give a draw.
    for (int i = 0; i < 19; i++) applyStimulus("draw", 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("drawWinner", int'(winner), 3);
    checkOutput("drawOver", int'(gameOver), 1);
    for (int i = 0; i < 5; i++) applyStimulus("drawHold", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-round with healthA = 1 and invulnA = 1.
    applyStimulus("restart2", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("pre1", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("pre2", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("pre3", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("preRstHealthA", int'(healthA), 1);
    checkOutput("preRstInvulnA", int'(invulnA), 1);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("asyncRst");
    #2;
    reset = 1'b0;

    // Randomized play with occasional restarts.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
